// File: rtl/ace_snoop_initiator.sv
// ace_snoop_initiator
// Issues a programmable sequence of ACE snoop requests on the AC channel.
// It collects each CR response and, when the response says data is coming,
// the CD data beats. It records the worst-case AC-to-CR response latency.
//
// Ports
//   ace_aclk, ace_aresetn      clock, synchronous active-low reset
//   i_control_reg              [0] en, [4:1] acsnoop, [12:5] num_snoops
//   i_base_addr_reg            first snoop address
//   i_stride_reg               address increment between snoops (wraps at 2^32)
//   i_timeout_reg              per-snoop response timeout in cycles, 0 = off
//   o_status_reg               [0] done, [1] err_timeout, [2] err_cdlast,
//                              [3] busy, [15:8] snoops completed
//   o_ac* / i_acready          AC snoop address channel (master)
//   i_cr* / o_crready          CR snoop response channel (slave)
//   i_cd* / o_cdready          CD snoop data channel (slave)
//   o_last_data                most recently accepted CD beat
//   o_max_latency              longest AC-handshake to CR-handshake time, cycles
module ace_snoop_initiator #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_ACE_DATA_WIDTH   = 128,
  parameter int C_ACE_ADDR_WIDTH   = 44,
  parameter int CD_BEATS           = 4
) (
  input  logic                          ace_aclk,
  input  logic                          ace_aresetn,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_control_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_base_addr_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_stride_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_timeout_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0] o_status_reg,
  output logic                          o_acvalid,
  output logic [C_ACE_ADDR_WIDTH-1:0]   o_acaddr,
  output logic [3:0]                    o_acsnoop,
  output logic [2:0]                    o_acprot,
  input  logic                          i_acready,
  input  logic                          i_crvalid,
  input  logic [4:0]                    i_crresp,
  output logic                          o_crready,
  input  logic                          i_cdvalid,
  input  logic [C_ACE_DATA_WIDTH-1:0]   i_cddata,
  input  logic                          i_cdlast,
  output logic                          o_cdready,
  output logic [C_ACE_DATA_WIDTH-1:0]   o_last_data,
  output logic [31:0]                   o_max_latency
);

  localparam int BEAT_W = $clog2(CD_BEATS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_CR, S_WAIT_CD, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t              state;
  logic [31:0]         addr;
  logic [7:0]          num_lat;
  logic [7:0]          completed;
  logic [31:0]         elapsed;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                done;
  logic                err_timeout;
  logic                err_cdlast;

  logic                en;
  logic [3:0]          ctl_snoop;
  logic [7:0]          ctl_num;
  logic [31:0]         elapsed_n;
  logic                timeout_hit;
  logic                ac_hs;
  logic                cr_hs;
  logic                cd_hs;
  logic [BEAT_W-1:0]   beat_n;
  logic [7:0]          completed_n;
  logic [31:0]         addr_n;
  logic                busy;
  logic                unused_ok;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [C_ACE_ADDR_WIDTH-1:0] ext_addr(input logic [31:0] a);
    return C_ACE_ADDR_WIDTH'(a);
  endfunction

  assign en          = i_control_reg[0];
  assign ctl_snoop   = i_control_reg[4:1];
  assign ctl_num     = i_control_reg[12:5];
  assign ac_hs       = o_acvalid & i_acready;
  assign cr_hs       = o_crready & i_crvalid;
  assign cd_hs       = o_cdready & i_cdvalid;
  assign beat_n      = beat_cnt + BEAT_W'(1);
  assign completed_n = completed + 8'd1;
  assign addr_n      = addr + i_stride_reg[31:0];

  // One counter serves as both response latency and timeout timer: it is
  // cleared at the AC handshake and runs through WAIT_CR and WAIT_CD.
  assign elapsed_n   = sat_inc(elapsed);
  // >= rather than == so a snoop that reached the limit exactly on its CR
  // handshake still times out in WAIT_CD instead of waiting forever.
  assign timeout_hit = (i_timeout_reg[31:0] != 32'd0) && (elapsed_n >= i_timeout_reg[31:0]);

  assign busy = (state == S_ISSUE) || (state == S_WAIT_CR) ||
                (state == S_WAIT_CD) || (state == S_NEXT);

  assign o_status_reg = C_S_AXI_DATA_WIDTH'({16'd0, completed, 4'd0,
                                             busy, err_cdlast, err_timeout, done});
  assign o_acprot     = 3'd0;

  assign unused_ok = ^{i_control_reg[C_S_AXI_DATA_WIDTH-1:13], i_crresp[4:1]};

  always_ff @(posedge ace_aclk) begin
    if (!ace_aresetn) begin
      state         <= S_IDLE;
      addr          <= '0;
      num_lat       <= '0;
      completed     <= '0;
      elapsed       <= '0;
      beat_cnt      <= '0;
      done          <= 1'b0;
      err_timeout   <= 1'b0;
      err_cdlast    <= 1'b0;
      o_acvalid     <= 1'b0;
      o_acaddr      <= '0;
      o_acsnoop     <= '0;
      o_crready     <= 1'b0;
      o_cdready     <= 1'b0;
      o_last_data   <= '0;
      o_max_latency <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en && !done && !err_timeout && !err_cdlast) begin
            num_lat       <= ctl_num;
            addr          <= i_base_addr_reg[31:0];
            completed     <= '0;
            elapsed       <= '0;
            beat_cnt      <= '0;
            o_max_latency <= '0;
            o_acsnoop     <= ctl_snoop;
            if (ctl_num == 8'd0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              o_acvalid <= 1'b1;
              o_acaddr  <= ext_addr(i_base_addr_reg[31:0]);
              state     <= S_ISSUE;
            end
          end
        end

        // AC outputs are registers that only change on the handshake, so
        // they stay stable while the interconnect back-pressures.
        S_ISSUE: begin
          if (ac_hs) begin
            o_acvalid <= 1'b0;
            o_crready <= 1'b1;
            elapsed   <= '0;
            state     <= S_WAIT_CR;
          end
        end

        // A CR handshake on the same edge as the timeout takes priority.
        S_WAIT_CR: begin
          elapsed <= elapsed_n;
          if (cr_hs) begin
            o_crready <= 1'b0;
            if (elapsed_n > o_max_latency) o_max_latency <= elapsed_n;
            if (i_crresp[0]) begin
              o_cdready <= 1'b1;
              beat_cnt  <= '0;
              state     <= S_WAIT_CD;
            end else begin
              state <= S_NEXT;
            end
          end else if (timeout_hit) begin
            o_crready   <= 1'b0;
            err_timeout <= 1'b1;
            state       <= S_ERROR;
          end
        end

        // The line must arrive as exactly CD_BEATS beats with cdlast on the
        // final one; any other framing is a protocol error.
        S_WAIT_CD: begin
          elapsed <= elapsed_n;
          if (cd_hs) begin
            o_last_data <= i_cddata;
            beat_cnt    <= beat_n;
            if (beat_n == BEAT_W'(CD_BEATS)) begin
              o_cdready <= 1'b0;
              if (i_cdlast) begin
                state <= S_NEXT;
              end else begin
                err_cdlast <= 1'b1;
                state      <= S_ERROR;
              end
            end else if (i_cdlast) begin
              o_cdready  <= 1'b0;
              err_cdlast <= 1'b1;
              state      <= S_ERROR;
            end
          end else if (timeout_hit) begin
            o_cdready   <= 1'b0;
            err_timeout <= 1'b1;
            state       <= S_ERROR;
          end
        end

        // en is only honoured here, between snoops, so a dropped enable
        // never leaves a half-finished transaction on the bus.
        S_NEXT: begin
          completed <= completed_n;
          addr      <= addr_n;
          if (completed_n == num_lat) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (!en) begin
            state <= S_IDLE;
          end else begin
            o_acvalid <= 1'b1;
            o_acaddr  <= ext_addr(addr_n);
            state     <= S_ISSUE;
          end
        end

        S_DONE: begin
          if (!en) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end

        S_ERROR: begin
          o_acvalid <= 1'b0;
          o_crready <= 1'b0;
          o_cdready <= 1'b0;
          if (!en) begin
            err_timeout <= 1'b0;
            err_cdlast  <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ace_snoop_initiator.md
ACE_SNOOP_INITIATOR -- requirements
Module: ace_snoop_initiator

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, control/status register width.
REQ-002 SHALL have parameter C_ACE_DATA_WIDTH, default 128, CD data width.
REQ-003 SHALL have parameter C_ACE_ADDR_WIDTH, default 44, AC address width.
REQ-004 SHALL have parameter CD_BEATS, default 4, CD beats per data-carrying response (64-byte line).
REQ-005 SHALL use one clock; reset is synchronous and active-low: ace_aclk  in  1  clock; ace_aresetn  in  1  synchronous active-low reset.
REQ-006 SHALL have i_control_reg  in  32  control: [0] en, [4:1] acsnoop, [12:5] num_snoops.
REQ-007 SHALL have i_base_addr_reg  in  32, first snoop address; i_stride_reg  in  32, address increment; i_timeout_reg  in  32, response timeout in cycles (0 = disabled).
REQ-008 SHALL have o_status_reg  out  32: [0] done, [1] err_timeout, [2] err_cdlast, [3] busy, [15:8] snoops completed.
REQ-009 SHALL have AC master ports: o_acvalid out 1; o_acaddr out C_ACE_ADDR_WIDTH; o_acsnoop out 4; o_acprot out 3 (constant 0); i_acready in 1.
REQ-010 SHALL have CR slave ports: i_crvalid in 1; i_crresp in 5; o_crready out 1.
REQ-011 SHALL have CD slave ports: i_cdvalid in 1; i_cddata in C_ACE_DATA_WIDTH; i_cdlast in 1; o_cdready out 1.
REQ-012 SHALL have o_last_data  out  C_ACE_DATA_WIDTH, last accepted CD beat; o_max_latency  out  32, max cycles from AC handshake to CR handshake.

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT_CR, WAIT_CD, NEXT, DONE, ERROR.
REQ-014 IDLE: busy=0; on en=1 with done=0 and no error bit set, latch acsnoop/num_snoops, load address=i_base_addr_reg, clear counters and o_max_latency, go ISSUE; if num_snoops=0 go DONE directly.
REQ-015 ISSUE: o_acvalid=1, o_acaddr={zeros, address[31:0]}, o_acsnoop=latched acsnoop; hold all AC outputs stable until i_acready=1; on handshake drop o_acvalid next cycle, go WAIT_CR.
REQ-016 WAIT_CR: o_crready=1; latency counter increments per cycle, saturating at 0xFFFFFFFF; on CR handshake update o_max_latency if counter greater; if i_crresp[0]=1 go WAIT_CD, else go NEXT.
REQ-017 WAIT_CD: o_cdready=1; each CD handshake latches i_cddata into o_last_data and increments beat count; on beat CD_BEATS with i_cdlast=1 go NEXT; i_cdlast=1 on an earlier beat or 0 on beat CD_BEATS sets err_cdlast, go ERROR.
REQ-018 o_cdready SHALL be 0 outside WAIT_CD; CD beats presented early remain stalled.
REQ-019 Timeout: when i_timeout_reg!=0 and cycles in WAIT_CR plus WAIT_CD for the current snoop equal i_timeout_reg, set err_timeout, deassert ready, go ERROR.
REQ-020 NEXT: increment snoops completed; address += i_stride_reg modulo 2^32 (wrap, no carry into [43:32]); if completed==num_snoops go DONE; else if en=0 go IDLE without done; else go ISSUE.
REQ-021 en=0 while in ISSUE/WAIT_CR/WAIT_CD SHALL NOT abort the transaction; takes effect in NEXT.
REQ-022 DONE: done=1; remain until en=0, then clear done and go IDLE.
REQ-023 ERROR: error bits sticky, all valid/ready outputs 0; on en=0 clear error bits, go IDLE.
REQ-024 busy SHALL be 1 in ISSUE, WAIT_CR, WAIT_CD, NEXT.
REQ-025 Simultaneous CR handshake and timeout match: handshake wins, no error.

Reset
REQ-026 While ace_aresetn=0 at a clock edge: state IDLE; o_acvalid, o_crready, o_cdready, o_acaddr, o_acsnoop, o_last_data, o_max_latency, o_status_reg all 0.
REQ-027 Reset mid-transaction SHALL abandon it immediately; no pending AC request is reissued after reset.

Verification
REQ-028 base=0x1000, stride=0x40, num=3, acsnoop=0x1, responder crresp=0 after 5 cycles -> addresses 0x1000,0x1040,0x1080; done=1; completed=3; o_max_latency=5.
REQ-029 crresp=0x01, 4 CD beats data 1..4, cdlast on beat 4 -> o_last_data=4, no error, done=1.
REQ-030 crresp=0x01, cdlast on beat 2 -> err_cdlast=1, state ERROR, o_cdready=0; en=0 -> status 0.
REQ-031 timeout=10, responder silent -> err_timeout=1 exactly 10 cycles after AC handshake; o_crready=0.
REQ-032 base=0xFFFFFFC0, stride=0x40, num=2 -> second o_acaddr=0x0, bits [43:32]=0.
REQ-033 i_acready held 0 for 8 cycles with en dropped in cycle 3 -> AC outputs stable, transaction completes, return IDLE, done=0.
